// File: rtl/ifetch_buffer.sv
// Fetch front end: owns the fetch PC, issues one-at-a-time imem requests
// and buffers returned {pc, word} pairs for decode, flushing on redirect.
module ifetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic [31:0]       word_q [DEPTH];
  logic [31:0]       word_d [DEPTH];

  logic          issue_ok;
  logic          grant;
  logic          push;
  logic          pop;
  logic [CW:0]   fill_nxt;

  assign pop      = instr_valid & instr_ready;
  assign fill_nxt = {1'b0, count_q} + (CW+1)'(1)
                  - (CW+1)'(pop);

  // WAIT may reissue in the response cycle: the slot it frees is reserved
  always_comb begin
    issue_ok = 1'b0;
    unique case (state_q)
      IDLE:    issue_ok = (count_q < DEPTH_C);
      WAIT:    issue_ok = imem_rvalid
                        & (fill_nxt < {1'b0, DEPTH_C});
      default: issue_ok = 1'b0;
    endcase
  end

  assign imem_req  = ~reset & ~redirect & issue_ok;
  assign imem_addr = fpc_q;
  assign grant     = imem_req & imem_gnt;
  assign push      = (state_q == WAIT) & imem_rvalid
                   & ~redirect;

  assign instr_valid = (count_q != '0) & ~redirect;
  assign instr       = instr_valid ? word_q[rd_q] : NOP;
  assign instr_pc    = instr_valid ? pc_q[rd_q] : '0;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    pc_d     = pc_q;
    word_d   = word_q;
    if (redirect) begin
      fpc_d   = redirect_pc & ALIGN;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      if (state_q == WAIT) begin
        state_d = imem_rvalid ? IDLE : DISCARD;
      end
    end else begin
      if (grant) begin
        req_pc_d = fpc_q;
        fpc_d    = fpc_q + ADDR_W'(4);
      end
      if (push) begin
        pc_d[wr_q]   = req_pc_q;
        word_d[wr_q] = imem_rdata;
        wr_d         = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      if (push & ~pop) begin
        count_d = count_q + CW'(1);
      end else if (pop & ~push) begin
        count_d = count_q - CW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (grant) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) state_d = grant ? WAIT : IDLE;
        end
        DISCARD: begin
          if (imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC & ALIGN;
      req_pc_q <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: a latency/grant-delay memory model
// feeds directed scenarios; a negedge monitor checks every delivery.
module tb_ifetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  ifetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int lat = 1;
  int gdl = 0;
  logic pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int rem = 0;
  int wcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] w,
                         input int c);
    exp_t e;
    e.pc = pc;
    e.word = w;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  task automatic drive_mem();
    imem_gnt    = (gdl == 0) || (wcnt >= gdl);
    imem_rvalid = pend && (rem == 0);
    imem_rdata  = imem_rvalid ? word_of(pend_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic step();
    logic fire, rv, rq;
    logic [31:0] fa;
    @(negedge clk);
    rq   = imem_req;
    fire = imem_req & imem_gnt;
    fa   = imem_addr;
    rv   = imem_rvalid;
    if (fire) chk("one_outstanding", {63'd0, pend & ~rv}, 64'd0);
    @(posedge clk);
    #1;
    if (rv) pend = 1'b0;
    else if (pend && rem > 0) rem--;
    if (fire) begin
      pend = 1'b1;
      pend_addr = fa;
      rem = lat - 1;
      wcnt = 0;
    end else if (rq) wcnt++;
    else wcnt = 0;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    pend = 1'b0;
    rem = 0;
    wcnt = 0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    drive_mem();
  endtask

  task automatic end_test();
    chk("sb_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid && instr_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got pc %0h expected none (cycle %0d)",
                   instr_pc, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_word", instr, e.word);
          chk("sb_cycle", cyc, e.cyc);
        end
      end else if (!instr_valid) begin
        chk("idle_instr", instr, NOP);
        chk("idle_pc", instr_pc, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // streaming, L=1, grant always
    lat = 1; gdl = 0;
    do_reset();
    sb_push(32'h0, 32'h0000_0093, 2);
    sb_push(32'h4, 32'h0004_0093, 3);
    sb_push(32'h8, 32'h0008_0093, 4);
    while (cyc < 5) begin
      #1;
      if (cyc == 0) begin
        chk("t1_first_req", imem_req, 1);
        chk("t1_first_addr", imem_addr, 0);
      end
      step();
    end
    end_test();

    // decode stalled, FIFO fills to DEPTH
    lat = 1; gdl = 0;
    do_reset();
    sb_push(32'h0, 32'h0000_0093, 6);
    sb_push(32'h4, 32'h0004_0093, 7);
    sb_push(32'h8, 32'h0008_0093, 9);
    while (cyc < 10) begin
      instr_ready = (cyc >= 6);
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        chk("t2_req_full", imem_req, 0);
        chk("t2_head_valid", instr_valid, 1);
        chk("t2_head_pc", instr_pc, 0);
      end
      step();
    end
    end_test();

    // L=3, grant delayed two cycles
    lat = 3; gdl = 2;
    do_reset();
    sb_push(32'h0, 32'h0000_0093, 6);
    sb_push(32'h4, 32'h0004_0093, 11);
    while (cyc < 14) begin
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        chk("t3_addr_hold", imem_addr, 32'h4);
        chk("t3_req_hold", imem_req, 1);
      end
      step();
    end
    end_test();

    // redirect while 0x8 outstanding
    lat = 3; gdl = 0;
    do_reset();
    sb_push(32'h0, 32'h0000_0093, 4);
    sb_push(32'h100, 32'h0100_0093, 14);
    while (cyc < 16) begin
      redirect = (cyc == 7);
      redirect_pc = 32'h100;
      #1;
      if (cyc == 7) chk("t4_valid_masked", instr_valid, 0);
      if (cyc == 8 || cyc == 9) chk("t4_no_req_discard", imem_req, 0);
      if (cyc == 10) begin
        chk("t4_req_target", imem_req, 1);
        chk("t4_addr_target", imem_addr, 32'h100);
      end
      step();
    end
    redirect = 1'b0;
    end_test();

    // redirect with rvalid, then redirects in WAIT and DISCARD
    lat = 3; gdl = 0;
    do_reset();
    sb_push(32'h200, 32'h0200_0093, 12);
    while (cyc < 14) begin
      redirect = (cyc == 3) || (cyc == 5) || (cyc == 6);
      redirect_pc = (cyc == 3) ? 32'h80 :
                    (cyc == 5) ? 32'h100 : 32'h203;
      #1;
      if (cyc == 3) chk("t5_req_redirect", imem_req, 0);
      if (cyc == 4) begin
        chk("t5_req_first", imem_req, 1);
        chk("t5_addr_first", imem_addr, 32'h80);
      end
      if (cyc == 7) chk("t5_no_req_drop", imem_req, 0);
      if (cyc == 8) begin
        chk("t5_req_final", imem_req, 1);
        chk("t5_addr_final", imem_addr, 32'h200);
      end
      step();
    end
    redirect = 1'b0;
    end_test();

    // reset while waiting for 0x40, late response ignored
    lat = 3; gdl = 0;
    do_reset();
    while (cyc < 2) begin
      redirect = (cyc == 0);
      redirect_pc = 32'h40;
      #1;
      step();
    end
    redirect = 1'b0;
    #2;
    chk("t6_pre_addr", imem_addr, 32'h44);
    reset = 1'b1;
    #1;
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_addr", imem_addr, 0);
    chk("t6_async_valid", instr_valid, 0);
    chk("t6_async_instr", instr, NOP);
    chk("t6_async_pc", instr_pc, 0);
    step();
    step();
    reset = 1'b0;
    cyc = 0;
    sb_push(32'h0, 32'h0000_0093, 4);
    #1;
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 0);
    while (cyc < 6) begin
      #1;
      step();
    end
    end_test();

    // fetch PC wraps past the top of the address space
    lat = 1; gdl = 0;
    do_reset();
    sb_push(32'hFFFF_FFFC, 32'hFFFC_0093, 3);
    sb_push(32'h0, 32'h0000_0093, 4);
    while (cyc < 5) begin
      redirect = (cyc == 0);
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      if (cyc == 2) chk("t7_wrap_addr", imem_addr, 0);
      step();
    end
    redirect = 1'b0;
    end_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
